// File: rtl/vscale_wb_arbiter_pkg.sv
// Shared definitions for the vscale writeback arbiter: the datapath widths
// normally supplied by rv32_opcodes.vh (defined here only if absent) and the
// arbiter state encoding.
`ifndef XPR_LEN
`define XPR_LEN 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

package vscale_wb_arbiter_pkg;

  localparam int unsigned NUM_REGS = 32;

  // IDLE: queue empty; PEND: entries waiting, primary wins; FORCE: head forced out
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PEND  = 2'd1,
    S_FORCE = 2'd2
  } arb_state_e;

  // One-hot pending flag for a destination register; x0 never reports busy
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [`REG_ADDR_WIDTH-1:0] wa);
    logic [NUM_REGS-1:0] oh;
    oh    = 32'd1 << wa;
    oh[0] = 1'b0;
    return oh;
  endfunction

endpackage

// File: rtl/vscale_wb_queue.sv
// Small FIFO holding secondary register writes until the register file port
// is free. Exposes per-slot valid bits and addresses for the scoreboard.
module vscale_wb_queue #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [AW-1:0]         push_wa,
  input  logic [DW-1:0]         push_wd,
  output logic                  full,
  output logic                  empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [AW-1:0]         head_wa,
  output logic [DW-1:0]         head_wd,
  output logic [DEPTH-1:0]      entry_valid,
  output logic [DEPTH*AW-1:0]   entry_wa
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0]    wa_q [DEPTH];
  logic [DW-1:0]    wd_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;

  // Pointer, occupancy and slot-valid bookkeeping for push/pop
  always_comb begin
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
  end

  // Control state; reset discards every queued entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, written at the tail on push
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        wa_q[i] <= '0;
        wd_q[i] <= '0;
      end
    end else if (push) begin
      wa_q[wr_ptr_q] <= push_wa;
      wd_q[wr_ptr_q] <= push_wd;
    end
  end

  // Flatten slot addresses for the scoreboard compare
  always_comb begin
    entry_wa = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_wa[i*AW +: AW] = wa_q[i];
    end
  end

  assign full        = (count_q == (PW+1)'(DEPTH));
  assign empty       = (count_q == '0);
  assign count       = count_q;
  assign head_wa     = wa_q[rd_ptr_q];
  assign head_wd     = wd_q[rd_ptr_q];
  assign entry_valid = valid_q;

endmodule

// File: rtl/vscale_wb_arbiter.sv
// Writeback arbiter: merges pipeline writebacks (primary, priority) with
// long-latency unit writes (secondary, always queued) onto the single
// register file write port. A queued head that waits STARVE_LIMIT cycles is
// forced out by stalling the pipeline for one cycle.
// Optional: define VSCALE_WB_SCOREBOARD_EN to drive sb_busy from the queue.
module vscale_wb_arbiter
  import vscale_wb_arbiter_pkg::*;
#(
  parameter int QUEUE_DEPTH  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       p_wen,
  input  logic [`REG_ADDR_WIDTH-1:0] p_wa,
  input  logic [`XPR_LEN-1:0]        p_wd,
  output logic                       wb_stall,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [`REG_ADDR_WIDTH-1:0] s_wa,
  input  logic [`XPR_LEN-1:0]        s_wd,
  output logic                       rf_wen,
  output logic [`REG_ADDR_WIDTH-1:0] rf_wa,
  output logic [`XPR_LEN-1:0]        rf_wd,
  output logic [31:0]                sb_busy
);

  localparam int AW   = `REG_ADDR_WIDTH;
  localparam int DW   = `XPR_LEN;
  localparam int CW   = $clog2(QUEUE_DEPTH) + 1;
  localparam int AGEW = $clog2(STARVE_LIMIT + 1);

  logic                      q_full_s, q_empty_s;
  logic [CW-1:0]             q_count_s;
  logic [AW-1:0]             head_wa_s;
  logic [DW-1:0]             head_wd_s;
  logic [QUEUE_DEPTH-1:0]    entry_valid_s;
  logic [QUEUE_DEPTH*AW-1:0] entry_wa_s;
  logic                      push_s, pop_s, sel_valid_s, last_pop_s;
  arb_state_e                state_q, state_d;
  logic [AGEW-1:0]           age_q, age_d;

  vscale_wb_queue #(
    .DEPTH (QUEUE_DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_queue (
    .clk         (clk),
    .reset_n     (reset_n),
    .push        (push_s),
    .pop         (pop_s),
    .push_wa     (s_wa),
    .push_wd     (s_wd),
    .full        (q_full_s),
    .empty       (q_empty_s),
    .count       (q_count_s),
    .head_wa     (head_wa_s),
    .head_wd     (head_wd_s),
    .entry_valid (entry_valid_s),
    .entry_wa    (entry_wa_s)
  );

  // No enqueue on a full queue, even if the head pops this cycle
  assign s_ready = reset_n && !q_full_s;
  assign push_s  = s_valid && s_ready;

  // Write-port source select: forced head, else primary, else queue head
  always_comb begin
    wb_stall    = 1'b0;
    pop_s       = 1'b0;
    sel_valid_s = 1'b0;
    rf_wa       = '0;
    rf_wd       = '0;
    if (!reset_n) begin
      sel_valid_s = 1'b0;
    end else if (state_q == S_FORCE) begin
      wb_stall    = 1'b1;
      pop_s       = !q_empty_s;
      sel_valid_s = !q_empty_s;
      rf_wa       = head_wa_s;
      rf_wd       = head_wd_s;
    end else if (p_wen) begin
      sel_valid_s = 1'b1;
      rf_wa       = p_wa;
      rf_wd       = p_wd;
    end else if (!q_empty_s) begin
      pop_s       = 1'b1;
      sel_valid_s = 1'b1;
      rf_wa       = head_wa_s;
      rf_wd       = head_wd_s;
    end else begin
      sel_valid_s = 1'b0;
    end
    // x0 writes are consumed but never reach the register file
    rf_wen = sel_valid_s && (rf_wa != '0);
  end

  // Head age and arbitration state transitions
  always_comb begin
    last_pop_s = pop_s && !push_s && (q_count_s == CW'(1));
    if (pop_s) begin
      age_d = '0;
    end else if ((state_q == S_PEND) && (age_q < AGEW'(STARVE_LIMIT))) begin
      age_d = age_q + AGEW'(1);
    end else begin
      age_d = age_q;
    end
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (push_s) state_d = S_PEND;
        else        state_d = S_IDLE;
      end
      S_PEND: begin
        if (last_pop_s)                          state_d = S_IDLE;
        else if (age_d == AGEW'(STARVE_LIMIT))   state_d = S_FORCE;
        else                                     state_d = S_PEND;
      end
      S_FORCE: begin
        if (last_pop_s) state_d = S_IDLE;
        else            state_d = S_PEND;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Arbitration state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      age_q   <= '0;
    end else begin
      state_q <= state_d;
      age_q   <= age_d;
    end
  end

`ifdef VSCALE_WB_SCOREBOARD_EN
  // Pending-write flags: any valid queued entry targeting the register
  always_comb begin
    sb_busy = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (entry_valid_s[i]) sb_busy = sb_busy | reg_onehot(entry_wa_s[i*AW +: AW]);
      else                  sb_busy = sb_busy;
    end
  end
`else
  logic unused_sb_s;
  assign sb_busy     = 32'h0;
  assign unused_sb_s = ^{entry_valid_s, entry_wa_s};
`endif

endmodule
